// File: rtl/bus_pkg.sv
// Shared constants for the IFU/LSU memory bus arbiter: FSM encoding,
// owner identifiers and default bus widths.
package bus_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/bus_arb_pick.sv
// Winner selection between IFU (req0) and LSU (req1).
// Round-robin when BUS_ARB_RR_EN is defined, otherwise fixed LSU priority.
module bus_arb_pick
    import bus_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner
);

`ifdef BUS_ARB_RR_EN
    // On contention the master that did not own the last response wins.
    always_comb begin
        if (req0 && req1) begin
            winner = ~last;
        end else if (req1) begin
            winner = OWN_LSU;
        end else begin
            winner = OWN_IFU;
        end
    end
`else
    logic last_unused;
    assign last_unused = last;

    always_comb begin
        winner = req1 ? OWN_LSU : OWN_IFU;
    end
`endif

endmodule

// File: rtl/bus_arbiter.sv
// Two-master (IFU, LSU) to one-slave memory bus arbiter, one transaction
// outstanding. Optional macro: BUS_ARB_RR_EN selects round-robin priority.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                m0_req_valid,
    output logic                m0_req_ready,
    input  logic [ADDR_W-1:0]   m0_req_addr,
    output logic                m0_rsp_valid,
    input  logic                m0_rsp_ready,
    output logic [DATA_W-1:0]   m0_rsp_rdata,
    output logic                m0_rsp_err,

    input  logic                m1_req_valid,
    output logic                m1_req_ready,
    input  logic [ADDR_W-1:0]   m1_req_addr,
    input  logic                m1_req_wen,
    input  logic [DATA_W-1:0]   m1_req_wdata,
    input  logic [DATA_W/8-1:0] m1_req_wmask,
    output logic                m1_rsp_valid,
    input  logic                m1_rsp_ready,
    output logic [DATA_W-1:0]   m1_rsp_rdata,
    output logic                m1_rsp_err,

    output logic                s_req_valid,
    input  logic                s_req_ready,
    output logic [ADDR_W-1:0]   s_req_addr,
    output logic                s_req_wen,
    output logic [DATA_W-1:0]   s_req_wdata,
    output logic [DATA_W/8-1:0] s_req_wmask,
    input  logic                s_rsp_valid,
    output logic                s_rsp_ready,
    input  logic [DATA_W-1:0]   s_rsp_rdata,
    input  logic                s_rsp_err
);

    logic [1:0] state_q, state_d;
    logic       owner_q, owner_d;
    logic       pick_last;
    logic       pick_winner;

`ifdef BUS_ARB_RR_EN
    logic last_q, last_d;
    assign pick_last = last_q;
`else
    assign pick_last = OWN_LSU;
`endif

    bus_arb_pick u_pick (
        .req0   (m0_req_valid),
        .req1   (m1_req_valid),
        .last   (pick_last),
        .winner (pick_winner)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
`ifdef BUS_ARB_RR_EN
        last_d       = last_q;
`endif
        m0_req_ready = 1'b0;
        m0_rsp_valid = 1'b0;
        m0_rsp_rdata = '0;
        m0_rsp_err   = 1'b0;
        m1_req_ready = 1'b0;
        m1_rsp_valid = 1'b0;
        m1_rsp_rdata = '0;
        m1_rsp_err   = 1'b0;
        s_req_valid  = 1'b0;
        s_req_addr   = '0;
        s_req_wen    = 1'b0;
        s_req_wdata  = '0;
        s_req_wmask  = '0;
        s_rsp_ready  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (m0_req_valid || m1_req_valid) begin
                    owner_d = pick_winner;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // A dropped valid simply stalls here; the grant is not revisited.
                if (owner_q == OWN_LSU) begin
                    s_req_valid  = m1_req_valid;
                    s_req_addr   = m1_req_addr;
                    s_req_wen    = m1_req_wen;
                    s_req_wdata  = m1_req_wdata;
                    s_req_wmask  = m1_req_wmask;
                    m1_req_ready = s_req_ready;
                    if (m1_req_valid && s_req_ready) begin
                        state_d = ST_RSP;
                    end
                end else begin
                    s_req_valid  = m0_req_valid;
                    s_req_addr   = m0_req_addr;
                    m0_req_ready = s_req_ready;
                    if (m0_req_valid && s_req_ready) begin
                        state_d = ST_RSP;
                    end
                end
            end
            ST_RSP: begin
                if (owner_q == OWN_LSU) begin
                    m1_rsp_valid = s_rsp_valid;
                    m1_rsp_rdata = s_rsp_rdata;
                    m1_rsp_err   = s_rsp_err;
                    s_rsp_ready  = m1_rsp_ready;
                end else begin
                    m0_rsp_valid = s_rsp_valid;
                    m0_rsp_rdata = s_rsp_rdata;
                    m0_rsp_err   = s_rsp_err;
                    s_rsp_ready  = m0_rsp_ready;
                end
                if (s_rsp_valid && s_rsp_ready) begin
                    state_d = ST_IDLE;
`ifdef BUS_ARB_RR_EN
                    last_d  = owner_q;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are forced quiet while reset is held, whatever the old state.
        if (rst) begin
            m0_req_ready = 1'b0;
            m0_rsp_valid = 1'b0;
            m0_rsp_rdata = '0;
            m0_rsp_err   = 1'b0;
            m1_req_ready = 1'b0;
            m1_rsp_valid = 1'b0;
            m1_rsp_rdata = '0;
            m1_rsp_err   = 1'b0;
            s_req_valid  = 1'b0;
            s_req_addr   = '0;
            s_req_wen    = 1'b0;
            s_req_wdata  = '0;
            s_req_wmask  = '0;
            s_rsp_ready  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_IFU;
`ifdef BUS_ARB_RR_EN
            last_q  <= OWN_LSU;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
`ifdef BUS_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter: inputs change on the falling
// edge, outputs are checked 1 ns later, state advances on the rising edge.
module tb_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req_valid, m0_req_ready, m0_rsp_valid, m0_rsp_ready, m0_rsp_err;
    logic [31:0] m0_req_addr, m0_rsp_rdata;
    logic        m1_req_valid, m1_req_ready, m1_req_wen, m1_rsp_valid, m1_rsp_ready, m1_rsp_err;
    logic [31:0] m1_req_addr, m1_req_wdata, m1_rsp_rdata;
    logic [3:0]  m1_req_wmask;
    logic        s_req_valid, s_req_ready, s_req_wen, s_rsp_valid, s_rsp_ready, s_rsp_err;
    logic [31:0] s_req_addr, s_req_wdata, s_rsp_rdata;
    logic [3:0]  s_req_wmask;

    int checks = 0;
    int errors = 0;

    bus_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready), .m0_rsp_rdata(m0_rsp_rdata),
        .m0_rsp_err(m0_rsp_err),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
        .m1_req_wen(m1_req_wen), .m1_req_wdata(m1_req_wdata), .m1_req_wmask(m1_req_wmask),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready), .m1_rsp_rdata(m1_rsp_rdata),
        .m1_rsp_err(m1_rsp_err),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr),
        .s_req_wen(s_req_wen), .s_req_wdata(s_req_wdata), .s_req_wmask(s_req_wmask),
        .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rsp_rdata(s_rsp_rdata),
        .s_rsp_err(s_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // OR of every output, used for the "all outputs quiet" checks.
    function automatic logic [31:0] all_out();
        return {31'd0, m0_req_ready | m0_rsp_valid | m0_rsp_err | m1_req_ready |
                m1_rsp_valid | m1_rsp_err | s_req_valid | s_req_wen | s_rsp_ready}
               | m0_rsp_rdata | m1_rsp_rdata | s_req_addr | s_req_wdata | {28'd0, s_req_wmask};
    endfunction

    logic [31:0] rr_exp_addr [4];

    initial begin
        rst = 1'b1;
        m0_req_valid = 0; m0_req_addr = 0; m0_rsp_ready = 0;
        m1_req_valid = 0; m1_req_addr = 0; m1_req_wen = 0; m1_req_wdata = 0;
        m1_req_wmask = 0; m1_rsp_ready = 0;
        s_req_ready = 0; s_rsp_valid = 0; s_rsp_rdata = 0; s_rsp_err = 0;

        // ---- reset state ----
        tick; tick;
        s_rsp_valid = 1; s_req_ready = 1; s_rsp_rdata = 32'h5555_AAAA;
        #1 chk("reset_outputs", all_out(), 32'h0);

        // ---- IFU-only read ----
        tick; rst = 0;
        m0_req_valid = 1; m0_req_addr = 32'h8000_0000; m0_rsp_ready = 1;
        s_rsp_rdata = 32'h0000_0413;
        #1 chk("ifu_c0_s_req_valid", {31'd0, s_req_valid}, 32'd0);
        tick;
        #1 chk("ifu_c1_s_req_valid", {31'd0, s_req_valid}, 32'd1);
        chk("ifu_c1_addr", s_req_addr, 32'h8000_0000);
        chk("ifu_c1_req_ready", {31'd0, m0_req_ready}, 32'd1);
        chk("ifu_c1_wen", {31'd0, s_req_wen}, 32'd0);
        tick; m0_req_valid = 0;
        #1 chk("ifu_c2_rsp_valid", {31'd0, m0_rsp_valid}, 32'd1);
        chk("ifu_c2_rdata", m0_rsp_rdata, 32'h0000_0413);
        chk("ifu_c2_m1_rsp_valid", {31'd0, m1_rsp_valid}, 32'd0);
        chk("ifu_c2_m1_rdata", m1_rsp_rdata, 32'd0);
        tick;
        #1 chk("ifu_c3_idle", all_out(), 32'h0);

        // ---- simultaneous requests: LSU first (also RR, since IFU owned last) ----
        m0_req_valid = 1; m0_req_addr = 32'h8000_0004;
        m1_req_valid = 1; m1_req_addr = 32'h8000_1000; m1_req_wen = 0; m1_rsp_ready = 1;
        s_rsp_rdata = 32'h1122_3344;
        #1 chk("sim_idle_m0_ready", {31'd0, m0_req_ready}, 32'd0);
        tick;
        #1 chk("sim_lsu_addr", s_req_addr, 32'h8000_1000);
        chk("sim_lsu_ready", {31'd0, m1_req_ready}, 32'd1);
        chk("sim_ifu_blocked_req", {31'd0, m0_req_ready}, 32'd0);
        tick; m1_req_valid = 0;
        #1 chk("sim_lsu_rdata", m1_rsp_rdata, 32'h1122_3344);
        chk("sim_ifu_blocked_rsp", {31'd0, m0_req_ready | m0_rsp_valid}, 32'd0);
        tick;
        #1 chk("sim_idle_gap", {31'd0, m0_req_ready | s_req_valid}, 32'd0);
        tick;
        #1 chk("sim_ifu_addr", s_req_addr, 32'h8000_0004);
        chk("sim_ifu_ready", {31'd0, m0_req_ready}, 32'd1);
        tick; m0_req_valid = 0;
        #1 chk("sim_ifu_rsp", {31'd0, m0_rsp_valid}, 32'd1);
        tick;

        // ---- continuous contention, 4 transactions after a fresh reset ----
        rst = 1;
        tick; rst = 0;
        m0_req_valid = 1; m0_req_addr = 32'h8000_0100;
        m1_req_valid = 1; m1_req_addr = 32'h8000_0200;
`ifdef BUS_ARB_RR_EN
        rr_exp_addr[0] = 32'h8000_0100; rr_exp_addr[1] = 32'h8000_0200;
        rr_exp_addr[2] = 32'h8000_0100; rr_exp_addr[3] = 32'h8000_0200;
`else
        rr_exp_addr[0] = 32'h8000_0200; rr_exp_addr[1] = 32'h8000_0200;
        rr_exp_addr[2] = 32'h8000_0200; rr_exp_addr[3] = 32'h8000_0200;
`endif
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("arb%0d_idle", i), {31'd0, s_req_valid}, 32'd0);
            tick;
            #1 chk($sformatf("arb%0d_grant_addr", i), s_req_addr, rr_exp_addr[i]);
            tick;
            #1 chk($sformatf("arb%0d_rsp_ready", i), {31'd0, s_rsp_ready}, 32'd1);
            tick;
        end
        m0_req_valid = 0; m1_req_valid = 0;
        tick;

        // ---- backpressured store ----
        s_req_ready = 0; s_rsp_valid = 1; s_rsp_err = 1; m1_rsp_ready = 0;
        m1_req_valid = 1; m1_req_addr = 32'h8000_2000; m1_req_wen = 1;
        m1_req_wdata = 32'hDEAD_BEEF; m1_req_wmask = 4'hF;
        tick;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("st_wait%0d_addr", i), s_req_addr, 32'h8000_2000);
            chk($sformatf("st_wait%0d_wdata", i), s_req_wdata, 32'hDEAD_BEEF);
            chk($sformatf("st_wait%0d_ctl", i),
                {26'd0, s_req_valid, s_req_wen, s_req_wmask}, {26'd0, 2'b11, 4'hF});
            chk($sformatf("st_wait%0d_ready", i), {31'd0, m1_req_ready}, 32'd0);
            tick;
        end
        s_req_ready = 1;
        #1 chk("st_req_handshake", {31'd0, m1_req_ready}, 32'd1);
        tick; m1_req_valid = 0;
        for (int i = 0; i < 2; i++) begin
            #1 chk($sformatf("st_rsp%0d_valid_err", i),
                   {30'd0, m1_rsp_valid, m1_rsp_err}, {30'd0, 2'b11});
            chk($sformatf("st_rsp%0d_s_ready", i), {31'd0, s_rsp_ready}, 32'd0);
            chk($sformatf("st_rsp%0d_s_req_quiet", i), s_req_addr | {31'd0, s_req_valid}, 32'd0);
            tick;
        end
        m1_rsp_ready = 1;
        #1 chk("st_rsp_handshake", {31'd0, s_rsp_ready}, 32'd1);
        tick;
        #1 chk("st_done_idle", {31'd0, m1_rsp_valid}, 32'd0);
        s_rsp_err = 0;

        // ---- reset during an IFU response ----
        m0_req_valid = 1; m0_req_addr = 32'h8000_0040; m0_rsp_ready = 0;
        tick;
        #1 chk("rst_ifu_req", {31'd0, m0_req_ready}, 32'd1);
        tick; m0_req_valid = 0;
        #1 chk("rst_ifu_rsp_pending", {31'd0, m0_rsp_valid}, 32'd1);
        rst = 1;
        #1 chk("rst_during_outputs", all_out(), 32'h0);
        tick; rst = 0;
        #1 chk("rst_after_outputs", all_out(), 32'h0);
        m1_req_valid = 1; m1_req_addr = 32'h8000_3000; m1_req_wen = 0; m1_rsp_ready = 1;
        tick;
        #1 chk("rst_lsu_grant", {30'd0, s_req_valid, m1_req_ready}, {30'd0, 2'b11});
        chk("rst_lsu_addr", s_req_addr, 32'h8000_3000);
        tick; m1_req_valid = 0;
        #1 chk("rst_lsu_rsp", {31'd0, m1_rsp_valid}, 32'd1);
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
